// File: rtl/loop_seq_pkg.sv
// Shared state encoding and default sizing for the loop_index_sequencer slice.
package loop_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } loop_seq_state_e;

    localparam int LOOP_SEQ_IDX_W = 4;
    localparam int LOOP_SEQ_LIMIT = 10;

endpackage

// File: rtl/loop_seq_rr_arb.sv
// Combinational round-robin pick: first asserted request after the pointer, wrapping.
module loop_seq_rr_arb
    import loop_seq_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        int              cand;
        logic [PTR_W-1:0] sel;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        sel     = '0;
        // The pointer itself is visited last, so the previous winner has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            sel  = PTR_W'(cand);
            if (!gnt_vld && req[sel]) begin
                gnt_vld     = 1'b1;
                gnt_idx     = sel;
                gnt_oh[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/loop_index_sequencer.sv
// Shared loop-index engine: arbitrates requesters, then steps the index one per clock to LIMIT.
// Optional LOOP_SEQ_ITER_COUNT_EN adds an iter_count output counting RUN cycles.
module loop_index_sequencer
    import loop_seq_pkg::*;
#(
    parameter int IDX_W = LOOP_SEQ_IDX_W,
    parameter int LIMIT = LOOP_SEQ_LIMIT,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][IDX_W-1:0] start_index,
    output logic [NREQ-1:0]            gnt,
    output logic [IDX_W-1:0]           index,
    output logic                       loop_active,
    output logic                       done,
    output logic                       done_ok,
    output logic                       busy
`ifdef LOOP_SEQ_ITER_COUNT_EN
    ,
    output logic [IDX_W-1:0]           iter_count
`endif
);

    localparam int               PTR_W   = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LIMIT_V = IDX_W'(LIMIT);
    localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(LIMIT - 1);

    loop_seq_state_e  state;
    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  arb_oh;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_vld;
    logic [IDX_W-1:0] start_sel;
    logic [IDX_W-1:0] index_inc;
    logic             owner_req;

    loop_seq_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign start_sel = start_index[arb_idx];
    assign index_inc = index + 1'b1;
    // The pointer always names the current owner once a grant is made.
    assign owner_req = req[rr_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(NREQ - 1);
            gnt         <= '0;
            index       <= '0;
            loop_active <= 1'b0;
            done        <= 1'b0;
            done_ok     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done    <= 1'b0;
            done_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        gnt    <= arb_oh;
                        rr_ptr <= arb_idx;
                        index  <= start_sel;
                        busy   <= 1'b1;
                        if (start_sel < LIMIT_V) begin
                            state       <= RUN;
                            loop_active <= 1'b1;
                        end else begin
                            state   <= FIN;
                            done    <= 1'b1;
                            done_ok <= (start_sel == LIMIT_V);
                        end
                    end
                end
                RUN: begin
                    // A dropped owner request wins over the final step: no done for aborts.
                    if (!owner_req) begin
                        state       <= IDLE;
                        gnt         <= '0;
                        loop_active <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        index <= index_inc;
                        if (index == LAST_V) begin
                            state       <= FIN;
                            loop_active <= 1'b0;
                            done        <= 1'b1;
                            done_ok     <= (index_inc == LIMIT_V);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    gnt         <= '0;
                    loop_active <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOOP_SEQ_ITER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_count <= '0;
        end else if (state == IDLE && arb_vld) begin
            iter_count <= '0;
        end else if (state == RUN && owner_req) begin
            iter_count <= iter_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/loop_index_sequencer.md
# loop_index_sequencer

Sequential, shared loop-index engine that replaces a combinational while-loop walk with one iteration per clock. Up to `NREQ` requesters compete for the engine through a round-robin arbiter. The granted requester's start index is stepped up to `LIMIT`, with the current index, an active flag and a completion flag published. The block sits between control requesters and any datapath that consumes an `(index, done)` loop-control pair.

## Interface
Parameters:
- `IDX_W`, 4: index width.
- `LIMIT`, 10: exclusive loop bound. Must satisfy `LIMIT <= 2**IDX_W - 1`, so the counter never wraps.
- `NREQ`, 2: number of requesters, range 2..8.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NREQ`: per-requester request; held high until `done` or abort.
- `start_index` in `NREQ x IDX_W`: per-requester start value; sampled only at grant.
- `gnt` out `NREQ`: one-hot grant, registered.
- `index` out `IDX_W`: current loop index.
- `loop_active` out 1: high while an iteration is being presented.
- `done` out 1: one-cycle completion pulse.
- `done_ok` out 1: valid with `done`; high iff the final index equals `LIMIT`.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, RUN, FIN.
- **Reset:** state=IDLE; `gnt`=0; `index`=0; `loop_active`=0; `done`=0; `done_ok`=0; `busy`=0; RR pointer=`NREQ-1`, so `req[0]` has first priority.
- **IDLE:** if any `req` is high, the arbiter picks the first requester after the RR pointer, wrapping. The block registers `gnt`, latches `start_index[g]` into `index`, and updates the pointer to g.
  - If `start_index[g] < LIMIT`, next state is RUN.
  - Otherwise next state is FIN, with zero iterations.
- **RUN:**
  - `loop_active`=1 and `index` = current value.
  - Each cycle `index` increments by 1.
  - When `index == LIMIT-1`, the increment lands on `LIMIT` and the next state is FIN.
- **FIN:** `done`=1 for exactly one cycle; `done_ok` = (`index == LIMIT`); `loop_active`=0; `gnt` still held. Next state is IDLE, with `gnt` cleared.
- **Zero-iteration cases:**
  - `start == LIMIT`: `done_ok`=1.
  - `start > LIMIT`: `done_ok`=0, and `index` holds the start value.
- **Abort:** if the granted `req` falls during RUN, next state is IDLE. No `done` pulse is issued, `gnt` clears, and the RR pointer keeps its update.
- **Requests:** non-granted requests are ignored and left pending. A request from the granted requester is ignored in FIN; it re-arbitrates in IDLE.
- **Arithmetic:** `index` is an `IDX_W`-bit unsigned value. The compare `index == LIMIT-1` uses `IDX_W` bits; no overflow is possible under the parameter rule above.

## Timing
- `req` is seen in IDLE at cycle t.
- At t+1, `gnt`, `busy` and `index=start` are valid.
- RUN lasts N = `LIMIT - start` cycles, from t+1 to t+N.
- FIN and `done` occur at t+N+1; IDLE is at t+N+2.
- For zero iterations: FIN at t+1, IDLE at t+2.
- IDLE always lasts at least one cycle, so the minimum grant-to-grant spacing is N+2 cycles.
- `rst` asserted in any state returns to reset values at the next edge. No `done` is issued for an interrupted loop.

## Configuration
- `LOOP_SEQ_ITER_COUNT_EN`
  - **Defined:** adds output `iter_count` [`IDX_W`]. It clears at grant, increments on each RUN cycle, and holds its value through FIN.
  - **Undefined:** the port and counter are absent, and all other behaviour is identical.

## Structure
- Package `loop_seq_pkg` holds the state enum `loop_seq_state_e` {IDLE, RUN, FIN} and the default constants `LOOP_SEQ_IDX_W`=4 and `LOOP_SEQ_LIMIT`=10.
- Sub-module `loop_seq_rr_arb` is a pure combinational round-robin pick: inputs are `req` and the pointer; outputs are a one-hot grant and an index. The FSM, counter and registers stay in the top module.

## Test plan
- **Basic run:** `req[0]`=1, start=7 → `gnt`=01 at t+1; `index` 7,8,9 with `loop_active`=1; `done`=1 and `done_ok`=1 at t+4; `busy`=0 at t+5.
- **Round robin:** both requests held, starts 8 and 9 → grant order 0,1,0,1; `done` pulses at the expected intervals of N+2 cycles.
- **Zero iterations:** start=10 → FIN at t+1 with `done_ok`=1; start=12 → `done_ok`=0, `index`=12, `loop_active` never high.
- **Abort:** start=2, drop `req` at the third RUN cycle → no `done`; IDLE on the next cycle; the next grant goes to the other requester.
- **Reset mid-run:** `rst` asserted during RUN with `index`=5 → all outputs at reset values on the next edge; `req[0]` is then granted first.
- **With `LOOP_SEQ_ITER_COUNT_EN`:** start=3 → `iter_count`=7 at FIN.
